nibbler_fetch_seq: RTL and testbench

//  Parametrised fetch/phase sequencer for the Nibbler-family core. It generates the

---
 rtl/nibbler_fetch_seq_if.sv | 32 +++
 rtl/nibbler_fetch_seq.sv | 65 ++++++
 tb/tb_nibbler_fetch_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibbler_fetch_seq_if.sv
// Fetch sequencer bus: run/stall/branch controls, ROM data and sequencer state outputs.
// The master side is the sequencer; the slave side is the core/ROM environment.
interface nibbler_fetch_seq_if #(
    parameter int PC_W   = 12,
    parameter int OPC_W  = 4,
    parameter int OPR_W  = 4,
    parameter int NPHASE = 2
);
    localparam int PH_W = (NPHASE > 2) ? $clog2(NPHASE) : 1;

    logic                    enable;
    logic                    stall;
    logic                    load_pc;
    logic [PC_W-1:0]         load_addr;
    logic [OPC_W+OPR_W-1:0]  program_byte;
    logic [PC_W-1:0]         pc;
    logic [PH_W-1:0]         phase;
    logic [OPC_W-1:0]        instr;
    logic [OPR_W-1:0]        oprnd;
    logic                    fetch_valid;
    logic                    pc_wrapped;

    modport master (
        input  enable, stall, load_pc, load_addr, program_byte,
        output pc, phase, instr, oprnd, fetch_valid, pc_wrapped
    );

    modport slave (
        output enable, stall, load_pc, load_addr, program_byte,
        input  pc, phase, instr, oprnd, fetch_valid, pc_wrapped
    );
endinterface

// File: rtl/nibbler_fetch_seq.sv
// Nibbler fetch/phase sequencer: owns the PC, steps NPHASE phases per instruction and
// latches {instr,oprnd} from the combinational program ROM in phase 0.
module nibbler_fetch_seq #(
    parameter int PC_W   = 12,
    parameter int OPC_W  = 4,
    parameter int OPR_W  = 4,
    parameter int NPHASE = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    nibbler_fetch_seq_if.master  bus
);
    localparam int PH_W = (NPHASE > 2) ? $clog2(NPHASE) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NPHASE - 1);

    logic [PC_W-1:0]  pc_q;
    logic [PH_W-1:0]  phase_q;
    logic [OPC_W-1:0] instr_q;
    logic [OPR_W-1:0] oprnd_q;
    logic             fetch_valid_q;
    logic             pc_wrapped_q;
    logic             advance;

    assign advance = bus.enable & ~bus.stall;

    // A non-advancing cycle holds everything; only the fetch pulse is cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= '0;
            phase_q       <= '0;
            instr_q       <= '0;
            oprnd_q       <= '0;
            fetch_valid_q <= 1'b0;
            pc_wrapped_q  <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            if (advance) begin
                if (phase_q == '0) begin
                    {instr_q, oprnd_q} <= bus.program_byte;
                    pc_q               <= pc_q + PC_W'(1);
                    fetch_valid_q      <= 1'b1;
                    phase_q            <= PH_W'(1);
                    if (&pc_q) begin
                        pc_wrapped_q <= 1'b1;
                    end
                end else if (phase_q == LAST_PHASE) begin
                    // Branches are taken only at the instruction boundary.
                    phase_q <= '0;
                    if (bus.load_pc) begin
                        pc_q <= bus.load_addr;
                    end
                end else begin
                    phase_q <= phase_q + PH_W'(1);
                end
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.phase       = phase_q;
    assign bus.instr       = instr_q;
    assign bus.oprnd       = oprnd_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.pc_wrapped  = pc_wrapped_q;
endmodule

// File: tb/tb_nibbler_fetch_seq.sv
// Bench for nibbler_fetch_seq: a 12-bit/2-phase instance and a 4-bit/3-phase instance,
// each checked every cycle against an instruction-level model plus directed literals.
module tb_nibbler_fetch_seq;
    logic clock;
    logic reset;
    logic run_chk;
    int   checks;
    int   failures;

    logic [7:0] rom_a [4096];
    logic [7:0] rom_b [16];

    typedef struct {
        int pc;
        int phase;
        int instr;
        int oprnd;
        int fv;
        int wrap;
    } mstate_t;

    mstate_t mod_a;
    mstate_t mod_b;

    nibbler_fetch_seq_if #(.PC_W(12), .OPC_W(4), .OPR_W(4), .NPHASE(2)) ifa ();
    nibbler_fetch_seq_if #(.PC_W(4),  .OPC_W(4), .OPR_W(4), .NPHASE(3)) ifb ();

    nibbler_fetch_seq #(.PC_W(12), .OPC_W(4), .OPR_W(4), .NPHASE(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    nibbler_fetch_seq #(.PC_W(4), .OPC_W(4), .OPR_W(4), .NPHASE(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    assign ifa.program_byte = rom_a[ifa.pc];
    assign ifb.program_byte = rom_b[ifb.pc];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One advancing edge executes one phase of the instruction; a fetch happens in phase 0.
    function automatic mstate_t step(input mstate_t m, input int pc_w, input int nphase,
                                     input int opr_w, input bit en, input bit st,
                                     input bit lp, input int la, input int pbyte);
        mstate_t n;
        n = m;
        n.fv = 0;
        if (en && !st) begin
            if (m.phase == 0) begin
                n.instr = pbyte >> opr_w;
                n.oprnd = pbyte % (1 << opr_w);
                if (m.pc == (1 << pc_w) - 1) n.wrap = 1;
                n.pc    = (m.pc + 1) % (1 << pc_w);
                n.fv    = 1;
                n.phase = 1;
            end else if (m.phase == nphase - 1) begin
                n.phase = 0;
                if (lp) n.pc = la;
            end else begin
                n.phase = m.phase + 1;
            end
        end
        return n;
    endfunction

    always begin : chk_a_proc
        mstate_t nxt;
        @(negedge clock);
        nxt = step(mod_a, 12, 2, 4, ifa.enable, ifa.stall, ifa.load_pc,
                   int'(ifa.load_addr), int'(rom_a[mod_a.pc]));
        @(posedge clock);
        #1;
        if (!reset) mod_a = '{default: 0};
        else        mod_a = nxt;
        if (run_chk) begin
            check("a_pc",    32'(ifa.pc),          mod_a.pc);
            check("a_phase", 32'(ifa.phase),       mod_a.phase);
            check("a_instr", 32'(ifa.instr),       mod_a.instr);
            check("a_oprnd", 32'(ifa.oprnd),       mod_a.oprnd);
            check("a_fv",    32'(ifa.fetch_valid), mod_a.fv);
            check("a_wrap",  32'(ifa.pc_wrapped),  mod_a.wrap);
        end
    end

    always begin : chk_b_proc
        mstate_t nxt;
        @(negedge clock);
        nxt = step(mod_b, 4, 3, 4, ifb.enable, ifb.stall, ifb.load_pc,
                   int'(ifb.load_addr), int'(rom_b[mod_b.pc]));
        @(posedge clock);
        #1;
        if (!reset) mod_b = '{default: 0};
        else        mod_b = nxt;
        if (run_chk) begin
            check("b_pc",    32'(ifb.pc),          mod_b.pc);
            check("b_phase", 32'(ifb.phase),       mod_b.phase);
            check("b_instr", 32'(ifb.instr),       mod_b.instr);
            check("b_oprnd", 32'(ifb.oprnd),       mod_b.oprnd);
            check("b_fv",    32'(ifb.fetch_valid), mod_b.fv);
            check("b_wrap",  32'(ifb.pc_wrapped),  mod_b.wrap);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus();
        // 12-bit / 2-phase: straight line, branch, stall, enable drop, async reset.
        reset = 1'b1;
        ifa.enable = 1'b1;
        tick();
        check("a_l_pc1", 32'(ifa.pc), 1);
        check("a_l_ph1", 32'(ifa.phase), 1);
        check("a_l_in1", 32'(ifa.instr), 1);
        check("a_l_op1", 32'(ifa.oprnd), 10);
        check("a_l_fv1", 32'(ifa.fetch_valid), 1);
        tick();
        check("a_l_ph0", 32'(ifa.phase), 0);
        check("a_l_fv0", 32'(ifa.fetch_valid), 0);
        tick();
        check("a_l_in2", 32'(ifa.instr), 2);
        check("a_l_op2", 32'(ifa.oprnd), 11);
        tick();
        tick();
        check("a_l_pc3", 32'(ifa.pc), 3);
        check("a_l_in3", 32'(ifa.instr), 3);
        check("a_l_op3", 32'(ifa.oprnd), 12);
        tick();
        tick();
        ifa.load_pc   = 1'b1;
        ifa.load_addr = 12'h0F0;
        tick();
        check("a_l_br", 32'(ifa.pc), 12'h0F0);
        tick();
        check("a_l_brf", 32'(ifa.pc), 12'h0F1);
        check("a_l_brin", 32'(ifa.instr), 5);
        ifa.load_pc = 1'b0;
        tick();
        ifa.stall = 1'b1;
        repeat (3) tick();
        check("a_l_stpc", 32'(ifa.pc), 12'h0F1);
        check("a_l_stph", 32'(ifa.phase), 0);
        check("a_l_stfv", 32'(ifa.fetch_valid), 0);
        ifa.stall = 1'b0;
        tick();
        check("a_l_rlpc", 32'(ifa.pc), 12'h0F2);
        check("a_l_rlop", 32'(ifa.oprnd), 15);
        check("a_l_rlfv", 32'(ifa.fetch_valid), 1);
        ifa.enable    = 1'b0;
        ifa.load_pc   = 1'b1;
        ifa.load_addr = 12'h000;
        repeat (2) tick();
        check("a_l_enph", 32'(ifa.phase), 1);
        check("a_l_enpc", 32'(ifa.pc), 12'h0F2);
        ifa.load_pc = 1'b0;
        ifa.enable  = 1'b1;
        tick();
        tick();
        ifa.load_pc   = 1'b1;
        ifa.load_addr = 12'h004;
        tick();
        ifa.load_pc = 1'b0;
        tick();
        check("a_l_pc5", 32'(ifa.pc), 5);
        #1 reset = 1'b0;
        #1;
        check("a_r_pc",   32'(ifa.pc), 0);
        check("a_r_ph",   32'(ifa.phase), 0);
        check("a_r_in",   32'(ifa.instr), 0);
        check("a_r_op",   32'(ifa.oprnd), 0);
        check("a_r_fv",   32'(ifa.fetch_valid), 0);
        check("a_r_wrap", 32'(ifa.pc_wrapped), 0);
        tick();
        reset = 1'b1;
        tick();
        check("a_l_restart", 32'(ifa.instr), 1);
        ifa.enable = 1'b0;

        // 4-bit / 3-phase: branch gating, load to 0, wrap stickiness.
        ifb.enable = 1'b1;
        tick();
        ifb.load_pc   = 1'b1;
        ifb.load_addr = 4'h9;
        tick();
        check("b_l_ph2", 32'(ifb.phase), 2);
        check("b_l_ign", 32'(ifb.pc), 1);
        ifb.load_addr = 4'h0;
        tick();
        check("b_l_ld0", 32'(ifb.pc), 0);
        check("b_l_nw0", 32'(ifb.pc_wrapped), 0);
        ifb.load_addr = 4'hF;
        tick();
        check("b_l_p0ign", 32'(ifb.pc), 1);
        tick();
        tick();
        check("b_l_ldF", 32'(ifb.pc), 15);
        ifb.load_pc = 1'b0;
        tick();
        check("b_l_wpc", 32'(ifb.pc), 0);
        check("b_l_wrap", 32'(ifb.pc_wrapped), 1);
        check("b_l_win", 32'(ifb.instr), 15);
        check("b_l_wop", 32'(ifb.oprnd), 0);
        tick();
        ifb.load_pc   = 1'b1;
        ifb.load_addr = 4'h3;
        tick();
        check("b_l_ld3", 32'(ifb.pc), 3);
        check("b_l_wst", 32'(ifb.pc_wrapped), 1);
        ifb.load_pc = 1'b0;
        tick();
        check("b_l_pc4", 32'(ifb.pc), 4);
        #1 reset = 1'b0;
        #1;
        check("b_r_wrap", 32'(ifb.pc_wrapped), 0);
        check("b_r_pc",   32'(ifb.pc), 0);
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        run_chk  = 1'b0;
        mod_a    = '{default: 0};
        mod_b    = '{default: 0};
        for (int i = 0; i < 4096; i++) rom_a[i] = 8'h00;
        rom_a[0]      = 8'h1A;
        rom_a[1]      = 8'h2B;
        rom_a[2]      = 8'h3C;
        rom_a[3]      = 8'h4D;
        rom_a[12'h0F0] = 8'h5E;
        rom_a[12'h0F1] = 8'h6F;
        for (int i = 0; i < 16; i++) rom_b[i] = 8'((i << 4) | (15 - i));
        reset = 1'b1;
        ifa.enable = 1'b0; ifa.stall = 1'b0; ifa.load_pc = 1'b0; ifa.load_addr = '0;
        ifb.enable = 1'b0; ifb.stall = 1'b0; ifb.load_pc = 1'b0; ifb.load_addr = '0;
        #1 reset = 1'b0;
        #1 run_chk = 1'b1;
        tick();
        tick();
        check("rst_pc",  32'(ifa.pc), 0);
        check("rst_ph",  32'(ifa.phase), 0);
        check("rst_bpc", 32'(ifb.pc), 0);
        applyStimulus();
        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
